// File: rtl/config_readback_pkg.sv
// Shared types and width helpers for the configuration read-back deserialiser.
package config_readback_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } state_t;

    // Counter wide enough to hold 0..max_bits inclusive.
    function automatic int cnt_width(input int max_bits);
        return $clog2(max_bits + 1);
    endfunction

    // FIFO occupancy needs one extra bit so "full" is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/readback_word_fifo.sv
// First-word-fall-through word FIFO; head word is visible combinationally.
module readback_word_fifo
    import config_readback_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = level_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [LW-1:0]         level
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop   = pop && (level != '0);
    assign do_push  = push && ((level != LW'(FIFO_DEPTH)) || do_pop);
    assign rd_valid = (level != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (do_pop && !do_push) level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/config_readback_deser.sv
// Samples ConfigOut on ConfigClk falling edges, packs LSB-first words and
// buffers them for a valid/ready reader.
module config_readback_deser
    import config_readback_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int CONFIG_REG_WIDTH = 5164,
    parameter int FIFO_DEPTH       = 16,
    parameter int SYNC_STAGES      = 2,
    localparam int CNT_W = cnt_width(CONFIG_REG_WIDTH),
    localparam int LVL_W = level_width(FIFO_DEPTH)
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  config_clk,
    input  logic                  config_out,
    input  logic                  start,
    input  logic [CNT_W-1:0]      bit_count,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [CNT_W-1:0]      bits_captured,
    output logic [LVL_W-1:0]      fifo_level
);

    localparam int IDX_W = $clog2(DATA_WIDTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   cout_s;
    logic                   clk_q;
    logic                   cfg_fall;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       remaining;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic [DATA_WIDTH-1:0]  word_next;
    logic                   capture_bit;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;

    assign cout_s    = sync_q[SYNC_STAGES-1];
    assign cfg_fall  = clk_q & ~config_clk;
    assign busy      = (state != IDLE);
    assign pop       = rd_valid & rd_ready;
    assign fifo_full = (fifo_level == LVL_W'(FIFO_DEPTH));

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            sync_q <= '0;
            clk_q  <= 1'b0;
        end else begin
            sync_q[0] <= config_out;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            clk_q <= config_clk;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) state <= IDLE;
        else                state <= state_next;
    end

    // Partial word with the bit being sampled this cycle already merged in.
    always_comb begin
        word_next          = shift_q;
        word_next[bit_idx] = cout_s;
    end

    always_comb begin
        state_next  = state;
        capture_bit = 1'b0;
        push        = 1'b0;
        case (state)
            IDLE: begin
                if (start && (bit_count != '0)) state_next = ARM;
            end
            ARM: begin
                if (config_clk) state_next = CAPTURE;
            end
            CAPTURE: begin
                if (cfg_fall) begin
                    capture_bit = 1'b1;
                    if ((bit_idx == IDX_W'(DATA_WIDTH - 1)) || (remaining == CNT_W'(1)))
                        push = 1'b1;
                    if (remaining == CNT_W'(1)) state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next  = IDLE;
            capture_bit = 1'b0;
            push        = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            remaining     <= '0;
            bits_captured <= '0;
            bit_idx       <= '0;
            shift_q       <= '0;
            done          <= 1'b0;
            overflow      <= 1'b0;
        end else if (abort) begin
            bit_idx  <= '0;
            shift_q  <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                if (bit_count == '0) begin
                    done <= 1'b1;
                end else begin
                    remaining     <= bit_count;
                    bits_captured <= '0;
                    bit_idx       <= '0;
                    shift_q       <= '0;
                    done          <= 1'b0;
                    overflow      <= 1'b0;
                end
            end
            // Clearing on push keeps the unfilled upper bits of a final word zero.
            if (capture_bit) begin
                shift_q       <= push ? '0 : word_next;
                bits_captured <= bits_captured + CNT_W'(1);
                remaining     <= remaining - CNT_W'(1);
                bit_idx       <= (bit_idx == IDX_W'(DATA_WIDTH - 1)) ? '0 : bit_idx + IDX_W'(1);
            end
            if (push && fifo_full && !pop) overflow <= 1'b1;
            if (state == DONE) done <= 1'b1;
        end
    end

    readback_word_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .push      (push),
        .push_data (word_next),
        .pop       (pop),
        .flush     (abort),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_config_readback_deser.sv
// Directed and randomized bench for config_readback_deser with a bit-list
// reference model that packs expected words arithmetically.
module tb_config_readback_deser;

    localparam int DW    = 32;
    localparam int CRW   = 5164;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(CRW + 1);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int HALF  = 4;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic             config_clk = 1'b0;
    logic             config_out = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] bit_count = '0;
    logic             abort = 1'b0;
    logic [DW-1:0]    rd_data;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [CNT_W-1:0] bits_captured;
    logic [LVL_W-1:0] fifo_level;

    int checks = 0;
    int errors = 0;
    int div_cnt = 0;

    bit          stim_bits[$];
    bit          chip_q[$];
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    config_readback_deser dut (
        .S_AXI_ACLK    (aclk),
        .S_AXI_ARESETN (aresetn),
        .config_clk    (config_clk),
        .config_out    (config_out),
        .start         (start),
        .bit_count     (bit_count),
        .abort         (abort),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .bits_captured (bits_captured),
        .fifo_level    (fifo_level)
    );

    always #5 aclk = ~aclk;

    // ConfigClk divider; the chip shifts its next bit out on each rising edge.
    always @(negedge aclk) begin
        if (div_cnt == HALF - 1) begin
            div_cnt = 0;
            config_clk = ~config_clk;
            if (config_clk)
                config_out = (chip_q.size() > 0) ? chip_q.pop_front() : 1'($urandom_range(1));
        end else begin
            div_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic make_bits(input int n, input int mode);
        stim_bits.delete();
        for (int i = 0; i < n; i++) begin
            case (mode)
                1:       stim_bits.push_back(1'b1);
                2:       stim_bits.push_back((i % 2) == 0);
                default: stim_bits.push_back(1'($urandom_range(1)));
            endcase
        end
    endtask

    // Word k holds bits 32k..32k+31, bit 32k in the LSB; missing bits are zero.
    task automatic build_expected(input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            if ((i % DW) == 0) exp_q.push_back(32'h0);
            exp_q[i / DW] = exp_q[i / DW] | (32'(stim_bits[i]) << (i % DW));
        end
    endtask

    task automatic start_capture(input int n);
        @(negedge config_clk);
        chip_q = stim_bits;
        bit_count = CNT_W'(n);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (rd_valid && rd_ready) got_q.push_back(rd_data);
            @(negedge aclk);
        end
        check({tag, "_timeout"}, 64'(timed_out), 64'd0);
    endtask

    task automatic wait_bits(input int n, input int budget, input string tag);
        bit timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (bits_captured == CNT_W'(n)) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge aclk);
        end
        check({tag, "_timeout"}, 64'(timed_out), 64'd0);
    endtask

    task automatic drain(input int budget);
        rd_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (!rd_valid) break;
            got_q.push_back(rd_data);
            @(negedge aclk);
        end
        rd_ready = 1'b0;
    endtask

    task automatic compare_words(input string tag);
        int n;
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    function automatic int budget_for(input int n);
        return n * 2 * HALF + 8 * HALF + 40;
    endfunction

    initial begin
        // Reset state
        repeat (3) @(negedge aclk);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_bits", 64'(bits_captured), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // Fixed 8-bit pattern
        $display("[TB] 8-bit directed capture");
        stim_bits = '{1, 0, 1, 1, 0, 0, 1, 0};
        got_q.delete();
        start_capture(8);
        check("t1_busy", 64'(busy), 64'd1);
        wait_done(budget_for(8), "t1");
        check("t1_done", 64'(done), 64'd1);
        check("t1_bits", 64'(bits_captured), 64'd8);
        check("t1_level", 64'(fifo_level), 64'd1);
        check("t1_head", 64'(rd_data), 64'h4D);
        drain(40);
        build_expected(8);
        compare_words("t1");

        // 64 alternating bits, consumer always ready
        $display("[TB] 64-bit alternating capture");
        make_bits(64, 2);
        got_q.delete();
        rd_ready = 1'b1;
        start_capture(64);
        wait_done(budget_for(64), "t2");
        drain(40);
        build_expected(64);
        compare_words("t2");
        if (got_q.size() > 0) check("t2_first", 64'(got_q[0]), 64'h55555555);
        check("t2_overflow", 64'(overflow), 64'd0);

        // Full-length all-ones capture, drained continuously
        $display("[TB] 5164-bit capture");
        make_bits(CRW, 1);
        got_q.delete();
        rd_ready = 1'b1;
        start_capture(CRW);
        wait_done(budget_for(CRW), "t3");
        drain(40);
        build_expected(CRW);
        compare_words("t3");
        check("t3_nwords", 64'(got_q.size()), 64'd162);
        if (got_q.size() > 0) check("t3_last", 64'(got_q[got_q.size() - 1]), 64'hFFF);
        check("t3_overflow", 64'(overflow), 64'd0);
        check("t3_bits", 64'(bits_captured), 64'(CRW));

        // Overflow: 20 words into a 16-deep FIFO with no consumer
        $display("[TB] overflow capture");
        make_bits(DW * 20, 0);
        got_q.delete();
        rd_ready = 1'b0;
        start_capture(DW * 20);
        wait_done(budget_for(DW * 20), "t4");
        check("t4_level", 64'(fifo_level), 64'(DEPTH));
        check("t4_overflow", 64'(overflow), 64'd1);
        check("t4_done", 64'(done), 64'd1);
        drain(60);
        build_expected(DW * 20);
        while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        compare_words("t4");

        // Abort mid-capture, then a normal short capture
        $display("[TB] abort mid-capture");
        make_bits(100, 0);
        got_q.delete();
        start_capture(100);
        wait_bits(40, budget_for(40), "t5");
        check("t5_level_pre", 64'(fifo_level), 64'd1);
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_rd_valid", 64'(rd_valid), 64'd0);
        check("t5_level", 64'(fifo_level), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        check("t5_bits_held", 64'(bits_captured), 64'd40);
        make_bits(4, 0);
        got_q.delete();
        start_capture(4);
        wait_done(budget_for(4), "t5b");
        check("t5b_bits", 64'(bits_captured), 64'd4);
        drain(40);
        build_expected(4);
        compare_words("t5b");

        // Zero-length capture
        $display("[TB] zero-length start");
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        check("t6_done_cleared", 64'(done), 64'd0);
        bit_count = '0;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        check("t6_done", 64'(done), 64'd1);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_rd_valid", 64'(rd_valid), 64'd0);
        @(negedge aclk);
        check("t6_rd_valid_later", 64'(rd_valid), 64'd0);

        // Second start during a capture must not disturb it
        $display("[TB] start while busy");
        make_bits(16, 0);
        got_q.delete();
        start_capture(16);
        wait_bits(5, budget_for(5), "t7");
        bit_count = CNT_W'(5);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        wait_done(budget_for(16), "t7");
        check("t7_bits", 64'(bits_captured), 64'd16);
        drain(40);
        build_expected(16);
        compare_words("t7");

        // Asynchronous reset in the middle of a capture
        $display("[TB] reset mid-capture");
        make_bits(50, 0);
        got_q.delete();
        start_capture(50);
        wait_bits(10, budget_for(10), "t8");
        check("t8_busy_pre", 64'(busy), 64'd1);
        aresetn = 1'b0;
        #1;
        check("t8_busy", 64'(busy), 64'd0);
        check("t8_bits", 64'(bits_captured), 64'd0);
        check("t8_rd_valid", 64'(rd_valid), 64'd0);
        check("t8_level", 64'(fifo_level), 64'd0);
        check("t8_done", 64'(done), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        check("t8_idle_after", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_readback_deser.md
Name: config_readback_deser

Overview:
- Downstream stage of the configuration shift-register driver.
- Samples the chip's serial ConfigOut pin on each ConfigClk falling edge and packs the bits LSB-first into DATA_WIDTH-bit words.
- Buffers the words in a small FIFO and presents them on a valid/ready read port for the AXI register block.
- Lets software read back a whole shifted-out configuration (up to CONFIG_REG_WIDTH bits) instead of one bit per opcode.

Parameters:
- DATA_WIDTH, 32: packed word width.
- CONFIG_REG_WIDTH, 5164: maximum bits per capture; CNT_W = $clog2(CONFIG_REG_WIDTH+1).
- FIFO_DEPTH, 16: word FIFO entries; must be a power of two.
- SYNC_STAGES, 2: synchroniser flops on config_out.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- config_clk  in  1  ConfigClk from the clock divider, already synchronous to S_AXI_ACLK.
- config_out  in  1  ConfigOut pin, asynchronous.
- start  in  1  one-cycle pulse that arms a capture.
- bit_count  in  CNT_W  number of bits to capture; latched on start.
- abort  in  1  one-cycle pulse: stop the capture, flush the FIFO, clear flags.
- rd_data  out  DATA_WIDTH  FIFO head word.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer accepts rd_data.
- busy  out  1  FSM not in IDLE.
- done  out  1  sticky; set at capture completion, cleared by start or abort.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- bits_captured  out  CNT_W  bits sampled in the current or last capture.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words held.

Behaviour:
- Reset values: rd_data 0, rd_valid 0, busy 0, done 0, overflow 0, bits_captured 0, fifo_level 0; FSM in IDLE; synchroniser flops 0.
- config_out passes through SYNC_STAGES flops; its value is cout_s.
- cfg_fall = clk_q & ~config_clk, where clk_q is config_clk delayed one cycle.
- The ConfigClk half-period must exceed SYNC_STAGES+1 ACLK cycles; this holds for the default divider of 100.
- FSM state IDLE:
  - start with bit_count=0: done set in the next cycle, no words produced, stay in IDLE.
  - start with bit_count>0: latch remaining=bit_count, clear bits_captured, done and overflow, go to ARM.
- FSM state ARM: wait for config_clk=1, then go to CAPTURE. This guarantees the first sample is a full-period falling edge.
- FSM state CAPTURE, on each cfg_fall:
  - shift[bits_captured mod DATA_WIDTH] <= cout_s (LSB-first).
  - bits_captured and remaining update by +1 and -1.
  - When the bit fills a word (bit index DATA_WIDTH-1), or remaining reaches 0, request a push in the same cycle; unfilled upper bits are 0.
  - When remaining reaches 0, go to DONE.
- FSM state DONE: set done in a single cycle, then go to IDLE.
- Push with FIFO full: word dropped, overflow set, capture continues. A simultaneous pop frees space, so the push succeeds.
- Pop: rd_valid & rd_ready advances the tail.
  - rd_data is the head word combinationally from the FIFO array, so there is 0-cycle read latency.
  - Pop and push in the same cycle keep fifo_level unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally; full means level==FIFO_DEPTH.
- start while busy is ignored.
- abort has priority over start and over any push or pop in the same cycle. It takes effect from any state: next cycle is IDLE, FIFO emptied, done=0, overflow=0, bits_captured held.
- Asynchronous reset mid-capture forces every reset value immediately; no partial word is emitted.
- Latency: a word is visible on rd_valid 1 cycle after the cfg_fall that completes it.

Decomposition:
- Package config_readback_pkg holds:
  - the state_t enum: IDLE, ARM, CAPTURE, DONE;
  - the CNT_W and level-width helper localparams.
- One sub-module, readback_word_fifo: a synchronous FWFT FIFO with parameters DATA_WIDTH and FIFO_DEPTH, push/pop/flush inputs, and level output.
- The synchroniser is inline.

Test Plan:
- bit_count=8; the chip shifts 1,0,1,1,0,0,1,0 -> one word 0x0000004D, done=1, bits_captured=8, fifo_level=1.
- bit_count=64 with alternating bits starting at 1, rd_ready held high -> words 0x55555555, 0x55555555; overflow=0.
- bit_count=5164, all ones, consumer drains continuously -> 162 words: 161 of 0xFFFFFFFF, last word 0x00000FFF.
- FIFO_DEPTH=16, bit_count=32*20, rd_ready=0 -> fifo_level=16, overflow=1, done=1; draining yields the first 16 words only.
- abort after 40 bits of a 100-bit capture -> next cycle busy=0, rd_valid=0, fifo_level=0; a following start with bit_count=4 works normally.
- start with bit_count=0 -> done=1 after 1 cycle, rd_valid stays 0. A second start pulse during a capture -> ignored; bit_count of the original capture is preserved.
